// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared FSM state encoding and wait-counter sizing for sram_ctrl
package sram_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, FINISH} state_t;
   function automatic int ctr_w(input int wait_cyc);
      return $clog2(wait_cyc + 1);
   endfunction
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready host port to async CS_n/OE_n/WE_n SRAM sequencer with wait states
// Ports: clk/reset (sync, active-high); req_* host request (valid/ready, we, addr, wdata);
//        rsp_* one-cycle completion pulse with access type and read data;
//        sram_* address, bidirectional data bus and active-low strobes.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 11,
   parameter int WAIT_CYC = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic              rsp_we,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0] sram_data,
   output logic              sram_cs_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);
   localparam int CW = ctr_w(WAIT_CYC);
   localparam logic [CW-1:0] LOAD = CW'(WAIT_CYC - 1);
   if (WAIT_CYC < 1) begin : g_bad_wait
      $error("sram_ctrl: WAIT_CYC must be >= 1");
   end
   state_t state, state_n;
   logic [CW-1:0] ctr;
   logic we, we_nx, drive, accept;
   logic [DATA_W-1:0] wdata;
   assign req_ready = state == IDLE && !reset;
   assign accept = req_valid && req_ready;
   assign sram_data = drive ? wdata : {DATA_W{1'bz}};
   // The access type is taken straight from the host on the accept edge,
   // since the latched copy is only valid one cycle later.
   always_comb begin
      we_nx = accept ? req_we : we;
      state_n = state == IDLE   ? (accept ? SETUP : IDLE) :
                state == SETUP  ? STROBE :
                state == STROBE ? (ctr == '0 ? FINISH : STROBE) : IDLE;
   end
   // Strobes and bus enable are registered from the next state so the SRAM
   // pins never glitch on decode.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ctr       <= '0;
         we        <= 1'b0;
         wdata     <= '0;
         drive     <= 1'b0;
         sram_addr <= '0;
         sram_cs_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_we    <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            we        <= req_we;
            wdata     <= req_wdata;
            sram_addr <= req_addr;
         end
         ctr <= state == SETUP ? LOAD : state == STROBE ? ctr - CW'(1) : ctr;
         if (state == STROBE && ctr == '0 && !we)
            rsp_rdata <= sram_data;
         // Write data stays on the bus through FINISH for hold time; a read
         // leaves it released there as the turnaround cycle.
         drive     <= state_n != IDLE && we_nx;
         sram_cs_n <= state_n == IDLE;
         sram_oe_n <= !(state_n == STROBE && !we_nx);
         sram_we_n <= !(state_n == STROBE && we_nx);
         rsp_valid <= state_n == FINISH;
         rsp_we    <= state_n == FINISH && we_nx;
      end
   end
endmodule
